// File: rtl/tm1637_key_scanner.sv
// Periodic TM1637 key-scan reader: one read-key frame per poll interval on the shared
// two-wire bus, with an N-scan debounce in front of the reported key code.
module tm1637_key_scanner #(
   parameter int CLK_DIV      = 100,
   parameter int POLL_CYCLES  = 500000,
   parameter int STABLE_SCANS = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       bus_gnt,
   output logic       bus_req,
   output logic       tm_clk,
   output logic       tm_dio_oe,
   input  logic       tm_dio_in,
   output logic       busy,
   output logic [7:0] key_code,
   output logic       key_pressed,
   output logic       key_valid,
   output logic       ack_err
);

   localparam int TMR_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int POLL_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;

   localparam logic [7:0]        CMD_READ_KEY = 8'h42;
   localparam logic [7:0]        NO_KEY       = 8'hFF;
   localparam logic [TMR_W-1:0]  TMR_LAST     = TMR_W'(CLK_DIV - 1);
   localparam logic [POLL_W-1:0] POLL_LAST    = POLL_W'(POLL_CYCLES - 1);
   localparam logic [2:0]        STABLE_N     = 3'(STABLE_SCANS);

   typedef enum logic [3:0] {
      S_IDLE,
      S_WAIT_GNT,
      S_START,
      S_CMD_BIT,
      S_CMD_ACK,
      S_RD_BIT,
      S_RD_ACK,
      S_STOP,
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [TMR_W-1:0]    tmr_q, tmr_d;
   logic [1:0]          ph_q, ph_d;
   logic [2:0]          bit_q, bit_d;
   logic [POLL_W-1:0]   poll_q, poll_d;
   logic [7:0]          shreg_q, shreg_d;
   logic                ack_ok_q, ack_ok_d;
   logic [7:0]          cand_q, cand_d;
   logic [2:0]          cnt_q, cnt_d;
   logic [7:0]          key_code_q, key_code_d;
   logic                key_pressed_q, key_pressed_d;
   logic                key_valid_q, key_valid_d;
   logic                ack_err_q, ack_err_d;
   logic                tm_clk_q, tm_clk_d;
   logic                dio_oe_q, dio_oe_d;
   logic                bus_req_q, bus_req_d;
   logic                busy_q, busy_d;
   logic                phase_end;

   assign phase_end = (tmr_q == TMR_LAST);

   always_comb begin
      state_d     = state_q;
      tmr_d       = phase_end ? '0 : tmr_q + TMR_W'(1);
      ph_d        = ph_q;
      bit_d       = bit_q;
      poll_d      = poll_q;
      shreg_d     = shreg_q;
      ack_ok_d    = ack_ok_q;
      cand_d      = cand_q;
      cnt_d       = cnt_q;
      key_code_d  = key_code_q;
      key_valid_d = 1'b0;
      ack_err_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            tmr_d = '0;
            if (enable) begin
               if (poll_q == POLL_LAST) begin
                  poll_d  = '0;
                  state_d = S_WAIT_GNT;
               end else begin
                  poll_d = poll_q + POLL_W'(1);
               end
            end
         end

         S_WAIT_GNT: begin
            tmr_d = '0;
            if (bus_gnt) begin
               state_d = S_START;
            end
         end

         S_START: begin
            if (phase_end) begin
               state_d = S_CMD_BIT;
               ph_d    = 2'd0;
               bit_d   = 3'd0;
            end
         end

         S_CMD_BIT: begin
            if (phase_end) begin
               if (ph_q == 2'd0) begin
                  ph_d = 2'd1;
               end else begin
                  ph_d = 2'd0;
                  if (bit_q == 3'd7) begin
                     state_d = S_CMD_ACK;
                  end else begin
                     bit_d = bit_q + 3'd1;
                  end
               end
            end
         end

         // The device pulls DIO low for the ACK; a high level means nobody answered.
         S_CMD_ACK: begin
            if (phase_end) begin
               if (ph_q == 2'd0) begin
                  ph_d = 2'd1;
               end else begin
                  ph_d  = 2'd0;
                  bit_d = 3'd0;
                  if (tm_dio_in) begin
                     ack_err_d = 1'b1;
                     ack_ok_d  = 1'b0;
                     cnt_d     = 3'd0;
                     state_d   = S_STOP;
                  end else begin
                     ack_ok_d = 1'b1;
                     state_d  = S_RD_BIT;
                  end
               end
            end
         end

         S_RD_BIT: begin
            if (phase_end) begin
               if (ph_q == 2'd0) begin
                  ph_d = 2'd1;
               end else begin
                  ph_d    = 2'd0;
                  shreg_d = {tm_dio_in, shreg_q[7:1]};
                  if (bit_q == 3'd7) begin
                     state_d = S_RD_ACK;
                  end else begin
                     bit_d = bit_q + 3'd1;
                  end
               end
            end
         end

         S_RD_ACK: begin
            if (phase_end) begin
               if (ph_q == 2'd0) begin
                  ph_d = 2'd1;
               end else begin
                  ph_d    = 2'd0;
                  state_d = S_STOP;
               end
            end
         end

         S_STOP: begin
            if (phase_end) begin
               if (ph_q == 2'd2) begin
                  ph_d    = 2'd0;
                  state_d = S_DONE;
               end else begin
                  ph_d = ph_q + 2'd1;
               end
            end
         end

         S_DONE: begin
            tmr_d   = '0;
            poll_d  = '0;
            state_d = S_IDLE;
            if (ack_ok_q) begin
               if (shreg_q == cand_q) begin
                  cnt_d = (cnt_q == 3'd7) ? cnt_q : cnt_q + 3'd1;
               end else begin
                  cand_d = shreg_q;
                  cnt_d  = 3'd1;
               end
               if ((cnt_d >= STABLE_N) && (cand_d != key_code_q)) begin
                  key_code_d  = cand_d;
                  key_valid_d = 1'b1;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      key_pressed_d = (key_code_d != NO_KEY);

      // Pin levels are decoded from the next state so they change together with it.
      tm_clk_d  = 1'b1;
      dio_oe_d  = 1'b0;
      bus_req_d = 1'b1;
      busy_d    = 1'b1;
      case (state_d)
         S_IDLE, S_DONE: begin
            bus_req_d = 1'b0;
            busy_d    = 1'b0;
         end
         S_START: begin
            dio_oe_d = 1'b1;
         end
         S_CMD_BIT: begin
            tm_clk_d = ph_d[0];
            dio_oe_d = ~CMD_READ_KEY[bit_d];
         end
         S_CMD_ACK, S_RD_BIT, S_RD_ACK: begin
            tm_clk_d = ph_d[0];
         end
         S_STOP: begin
            tm_clk_d = (ph_d != 2'd0);
            dio_oe_d = (ph_d != 2'd2);
         end
         default: begin
            tm_clk_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      shreg_q <= shreg_d;
      if (!rst) begin
         state_q       <= S_IDLE;
         tmr_q         <= '0;
         ph_q          <= 2'd0;
         bit_q         <= 3'd0;
         poll_q        <= '0;
         ack_ok_q      <= 1'b0;
         cand_q        <= NO_KEY;
         cnt_q         <= 3'd0;
         key_code_q    <= NO_KEY;
         key_pressed_q <= 1'b0;
         key_valid_q   <= 1'b0;
         ack_err_q     <= 1'b0;
         tm_clk_q      <= 1'b1;
         dio_oe_q      <= 1'b0;
         bus_req_q     <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         tmr_q         <= tmr_d;
         ph_q          <= ph_d;
         bit_q         <= bit_d;
         poll_q        <= poll_d;
         ack_ok_q      <= ack_ok_d;
         cand_q        <= cand_d;
         cnt_q         <= cnt_d;
         key_code_q    <= key_code_d;
         key_pressed_q <= key_pressed_d;
         key_valid_q   <= key_valid_d;
         ack_err_q     <= ack_err_d;
         tm_clk_q      <= tm_clk_d;
         dio_oe_q      <= dio_oe_d;
         bus_req_q     <= bus_req_d;
         busy_q        <= busy_d;
      end
   end

   assign bus_req     = bus_req_q;
   assign tm_clk      = tm_clk_q;
   assign tm_dio_oe   = dio_oe_q;
   assign busy        = busy_q;
   assign key_code    = key_code_q;
   assign key_pressed = key_pressed_q;
   assign key_valid   = key_valid_q;
   assign ack_err     = ack_err_q;

endmodule
